// File: rtl/solve_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : solve_sequencer
// Purpose  : Top-level scheduler for the klotski solver. Places tiles
//            1..N_TILES in row-major order by issuing one move_num job per
//            tile, waiting for its finish pulse and checking each placement.
//            Optional macro SOLVE_CYCLE_CNT_EN enables the o_cycles counter;
//            without it o_cycles is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module solve_sequencer #(
    parameter int N_TILES        = 12,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [63:0] i_klotski,
    output logic        o_mn_start,
    output logic [63:0] o_mn_klotski,
    output logic [15:0] o_mn_mask,
    output logic [3:0]  o_mn_target,
    output logic [3:0]  o_mn_number,
    input  logic [63:0] i_mn_klotski,
    input  logic [15:0] i_mn_mask,
    input  logic        i_mn_finished,
    output logic [63:0] o_klotski,
    output logic [3:0]  o_step,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [23:0] o_cycles
);

    localparam int          c_to_w      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  c_last_step = 4'(N_TILES);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    logic [2:0]        r_state;
    logic [63:0]       r_board;
    logic [15:0]       r_mask;
    logic [3:0]        r_step;
    logic [c_to_w-1:0] r_to;
    logic              r_mn_start;
    logic [3:0]        r_mn_target;
    logic [3:0]        r_mn_number;
    logic              r_busy;
    logic              r_done;
    logic              r_error;

    logic              w_accept;
    logic [3:0]        w_tgt;
    logic [3:0]        w_tile;
    logic              w_pass;

    // The target of tile n is {(n-1)>>2,(n-1)&3}, which is simply n-1 in 4 bits.
    assign w_accept = (r_state == S_IDLE) && i_start;
    assign w_tgt    = r_step - 4'd1;
    assign w_tile   = r_board[{w_tgt, 2'b00} +: 4];
    assign w_pass   = (w_tile == r_step) && r_mask[w_tgt];

    // Sequencer FSM; every output flop is loaded on the edge that enters the
    // state in which it must be visible, so all outputs come straight from flops.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_board     <= '0;
            r_mask      <= '0;
            r_step      <= '0;
            r_to        <= '0;
            r_mn_start  <= 1'b0;
            r_mn_target <= '0;
            r_mn_number <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_board     <= i_klotski;
                        r_mask      <= '0;
                        r_step      <= 4'd1;
                        r_error     <= 1'b0;
                        r_busy      <= 1'b1;
                        r_mn_start  <= 1'b1;
                        r_mn_number <= 4'd1;
                        r_mn_target <= 4'd0;
                        r_to        <= '0;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Timeout counter measures cycles since the start pulse.
                    r_mn_start <= 1'b0;
                    r_to       <= r_to + 1'b1;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_mn_finished) begin
                        r_board <= i_mn_klotski;
                        r_mask  <= i_mn_mask;
                        r_state <= S_CHECK;
                    end else if (r_to == c_to_last) begin
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_ERR;
                    end else begin
                        r_to <= r_to + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (!w_pass) begin
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_ERR;
                    end else if (r_step == c_last_step) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_step  <= 4'd0;
                        r_state <= S_DONE;
                    end else begin
                        r_step      <= r_step + 4'd1;
                        r_mn_start  <= 1'b1;
                        r_mn_number <= r_step + 4'd1;
                        r_mn_target <= r_step;
                        r_to        <= '0;
                        r_state     <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_ERR: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_mn_start   = r_mn_start;
    assign o_mn_klotski = r_board;
    assign o_mn_mask    = r_mask;
    assign o_mn_target  = r_mn_target;
    assign o_mn_number  = r_mn_number;
    assign o_klotski    = r_board;
    assign o_step       = r_step;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_error      = r_error;

`ifdef SOLVE_CYCLE_CNT_EN
    logic [23:0] r_cycles;

    // Solve-length counter: counts every non-idle cycle including the closing
    // DONE/ERR cycle, saturates, and holds until the next accepted start.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cycles <= '0;
        end else if (w_accept) begin
            r_cycles <= '0;
        end else if ((r_state != S_IDLE) && (r_cycles != 24'hFFFFFF)) begin
            r_cycles <= r_cycles + 24'd1;
        end
    end

    assign o_cycles = r_cycles;
`else
    assign o_cycles = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_solve_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_solve_sequencer
// Purpose  : Self-checking bench for solve_sequencer. A table of scenarios
//            drives a move_num stub; each scenario has hand-computed
//            expectations for starts, done, error, step and cycle count.
// Revision : 1.0 - initial release
// ============================================================================
module tb_solve_sequencer;

    localparam logic [63:0] c_solved = 64'h0FED_CBA9_8765_4321;
    localparam int          c_bound  = 6000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] klotski = '0;
    logic        mn_start;
    logic [63:0] mn_klotski_o;
    logic [15:0] mn_mask_o;
    logic [3:0]  mn_target;
    logic [3:0]  mn_number;
    logic [63:0] mn_klotski_i = '0;
    logic [15:0] mn_mask_i = '0;
    logic        mn_finished = 1'b0;
    logic [63:0] klotski_o;
    logic [3:0]  step;
    logic        busy;
    logic        done;
    logic        error;
    logic [23:0] cycles;

    int n_tests = 0;
    int n_fail  = 0;

    solve_sequencer dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_klotski     (klotski),
        .o_mn_start    (mn_start),
        .o_mn_klotski  (mn_klotski_o),
        .o_mn_mask     (mn_mask_o),
        .o_mn_target   (mn_target),
        .o_mn_number   (mn_number),
        .i_mn_klotski  (mn_klotski_i),
        .i_mn_mask     (mn_mask_i),
        .i_mn_finished (mn_finished),
        .o_klotski     (klotski_o),
        .o_step        (step),
        .o_busy        (busy),
        .o_done        (done),
        .o_error       (error),
        .o_cycles      (cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       lat;
        int       bad_step;
        int       hang_step;
        int       restart_step;
        int       rst_step;
        int       exp_starts;
        int       exp_dones;
        bit       exp_error;
        int       exp_step;
        int       exp_cyc;
    } vec_t;

    vec_t vecs[7];

    function automatic vec_t mk(input int lat, input int bad, input int hang, input int rs,
                                input int rst, input int starts, input int dones,
                                input bit err, input int stp, input int cyc);
        vec_t v;
        v.lat = lat; v.bad_step = bad; v.hang_step = hang; v.restart_step = rs;
        v.rst_step = rst; v.exp_starts = starts; v.exp_dones = dones;
        v.exp_error = err; v.exp_step = stp; v.exp_cyc = cyc;
        return v;
    endfunction

    task automatic check(input string nm, input int idx, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [vec %0d]: got %0h, expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic check_zero(input string nm, input int idx);
        check({nm, "_ctrl"}, idx, {mn_start, busy, done, error, mn_target, mn_number, step}, '0);
        check({nm, "_board"}, idx, klotski_o, '0);
        check({nm, "_mnmask"}, idx, {48'd0, mn_mask_o}, '0);
        check({nm, "_cycles"}, idx, {40'd0, cycles}, '0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int starts = 0;
        int dones = 0;
        int cyc = 0;
        int cnt = 0;
        int post = -1;
        int start_cyc = 0;
        int err_cyc = -1;
        bit pending = 0;
        bit restarted = 0;
        bit rst_pending = 0;
        logic [63:0] b;
        logic [3:0]  tmp;
        logic [63:0] ret_b = '0;
        logic [15:0] ret_m = '0;
        int exp_cyc;

        @(negedge clk);
        klotski = c_solved;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        check("busy_after_start", idx, {63'd0, busy}, 64'd1);
        while (cyc < c_bound) begin
            start       = 1'b0;
            mn_finished = 1'b0;
            if (rst_pending) begin
                rst_n = 1'b0;
                #1;
                check_zero("rst_mid", idx);
                @(negedge clk);
                rst_n = 1'b1;
                break;
            end
            if (pending) begin
                cnt--;
                if (cnt == 0) begin
                    pending      = 0;
                    mn_finished  = 1'b1;
                    mn_klotski_i = ret_b;
                    mn_mask_i    = ret_m;
                end
            end
            if (mn_start) begin
                starts++;
                check("mn_number", idx, {60'd0, mn_number}, 64'(starts));
                check("mn_target", idx, {60'd0, mn_target}, 64'(starts - 1));
                check("mn_mask", idx, {48'd0, mn_mask_o}, 64'((1 << (starts - 1)) - 1));
                b = mn_klotski_o;
                if (int'(mn_number) == v.bad_step) begin
                    tmp       = b[16 +: 4];
                    b[16 +: 4] = b[20 +: 4];
                    b[20 +: 4] = tmp;
                    ret_b = b;
                    ret_m = mn_mask_o | 16'h0020;
                end else begin
                    ret_b = b;
                    ret_m = mn_mask_o | (16'h0001 << mn_target);
                end
                if (int'(mn_number) == v.hang_step) begin
                    start_cyc = cyc;
                end else begin
                    pending = 1;
                    cnt     = v.lat;
                end
                if (int'(mn_number) == v.rst_step) rst_pending = 1;
            end
            if (v.restart_step != 0 && !restarted && busy && !mn_start &&
                int'(step) == v.restart_step) begin
                klotski   = '0;
                start     = 1'b1;
                restarted = 1;
            end
            if (done) dones++;
            if (error && err_cyc < 0) err_cyc = cyc;
            if ((done || error) && post < 0) post = 10;
            if (post == 0) break;
            if (post > 0) post--;
            @(negedge clk);
            cyc++;
        end
        start       = 1'b0;
        mn_finished = 1'b0;
        check("run_bound", idx, {63'd0, (cyc >= c_bound)}, 64'd0);
        check("starts", idx, 64'(starts), 64'(v.exp_starts));
        check("dones", idx, 64'(dones), 64'(v.exp_dones));
        check("error", idx, {63'd0, error}, {63'd0, v.exp_error});
        check("step", idx, {60'd0, step}, 64'(v.exp_step));
        check("busy_end", idx, {63'd0, busy}, 64'd0);
`ifdef SOLVE_CYCLE_CNT_EN
        exp_cyc = v.exp_cyc;
`else
        exp_cyc = 0;
`endif
        check("cycles", idx, {40'd0, cycles}, 64'(exp_cyc));
        if (v.exp_dones == 1) check("board_done", idx, klotski_o, c_solved);
        if (v.rst_step != 0) check("board_rst", idx, klotski_o, '0);
        if (v.hang_step != 0) check("timeout_dist", idx, 64'(err_cyc - start_cyc),
                                    64'd4096);
    endtask

    initial begin
        //            lat bad hang rs rst starts dones err step cycles(with counter)
        vecs[0] = mk(2,  0,  0,   0, 0,  12,    1,    0,  0,   49);
        vecs[1] = mk(2,  5,  0,   0, 0,  5,     0,    1,  5,   21);
        vecs[2] = mk(3,  0,  0,   0, 0,  12,    1,    0,  0,   61);
        vecs[3] = mk(2,  0,  3,   0, 0,  3,     0,    1,  3,   4105);
        vecs[4] = mk(2,  0,  0,   4, 0,  12,    1,    0,  0,   49);
        vecs[5] = mk(2,  0,  0,   0, 7,  7,     0,    0,  0,   0);
        vecs[6] = mk(2,  0,  0,   0, 0,  12,    1,    0,  0,   49);

        repeat (3) @(negedge clk);
        check_zero("reset", -1);
        rst_n = 1'b1;
        @(negedge clk);
        // A finish pulse while idle must be ignored.
        mn_finished  = 1'b1;
        mn_klotski_i = c_solved;
        @(negedge clk);
        mn_finished  = 1'b0;
        check("idle_finish", -1, {62'd0, busy, error}, 64'd0);
        check("idle_board", -1, klotski_o, '0);

        for (int i = 0; i < 7; i++) begin
            run_vec(i, vecs[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
